param_dif: RTL

PARAM_DIF -- requirements
Module: param_dif

---
 rtl/dif_pkg.sv | 32 +++
 rtl/dif_sat.sv | 30 +++
 rtl/param_dif.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dif_pkg.sv
// Shared definitions for the per-channel difference engine: FSM state
// encoding, channel-index width and the range check used for clamp/wrap.
package dif_pkg;

    // One-hot FSM states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_CALC = 3'b010,
        ST_HOLD = 3'b100
    } state_e;

    // Widest intermediate result the helpers must handle (DW max 24, +2 bits).
    localparam int FULL_MAX_W = 26;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int cw_of(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // True when a full-width signed value does not fit in dw signed bits.
    function automatic logic out_of_range(input logic signed [FULL_MAX_W-1:0] v,
                                          input int dw);
        longint vv;
        longint hi;
        longint lo;
        vv = longint'(v);
        hi = (longint'(1) <<< (dw - 1)) - 1;
        lo = -(longint'(1) <<< (dw - 1));
        return (vv > hi) || (vv < lo);
    endfunction

endpackage

// File: rtl/dif_sat.sv
// Full-width difference to DW-bit result, either clamped or wrapped,
// with a flag whenever the value did not fit.
module dif_sat
    import dif_pkg::*;
#(
    parameter int DW  = 13,
    parameter int SAT = 1
) (
    input  logic signed [DW+1:0] full_i,
    output logic        [DW-1:0] data_o,
    output logic                 flag_o
);

    localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

    logic ovf;

    // Wrap keeps the low bits; clamp replaces them by the nearest bound.
    // Overflow means the same thing in both modes, so the flag is shared.
    always_comb begin
        ovf    = out_of_range(FULL_MAX_W'(full_i), DW);
        data_o = full_i[DW-1:0];
        flag_o = ovf;
        if ((SAT != 0) && ovf) begin
            data_o = full_i[DW+1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/param_dif.sv
// Multi-channel first/second difference engine. One sample in flight:
// IDLE accepts, CALC computes and updates history, HOLD presents result.
module param_dif
    import dif_pkg::*;
#(
    parameter int DW  = 13,
    parameter int CH  = 4,
    parameter int SAT = 1,
    localparam int CW = cw_of(CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          order,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ch,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ch,
    output logic [DW-1:0] out_data,
    output logic          out_primed,
    output logic          out_sat
);

    state_e               state_q, state_d;
    logic        [CW-1:0] ch_q, ch_d;
    logic signed [DW-1:0] x_q, x_d;
    logic                 ord_q, ord_d;

    logic signed [DW-1:0] last1_q [CH];
    logic signed [DW-1:0] last1_d [CH];
    logic signed [DW-1:0] last2_q [CH];
    logic signed [DW-1:0] last2_d [CH];
    logic        [1:0]    cnt_q   [CH];
    logic        [1:0]    cnt_d   [CH];

    logic        [DW-1:0] out_data_q, out_data_d;
    logic        [CW-1:0] out_ch_q, out_ch_d;
    logic                 out_primed_q, out_primed_d;
    logic                 out_sat_q, out_sat_d;

    logic                 ch_ok;
    logic        [CW-1:0] idx;
    logic signed [DW-1:0] l1, l2;
    logic        [1:0]    cnt;
    logic signed [DW+1:0] xe, l1e, l2e, full;
    logic                 primed;
    logic        [DW-1:0] res_data;
    logic                 res_flag;

    // Fetch the latched channel's history and form the selected difference.
    // Out-of-range channels read entry 0 but nothing downstream uses it.
    always_comb begin
        ch_ok  = (32'(ch_q) < CH);
        idx    = ch_ok ? ch_q : '0;
        l1     = last1_q[idx];
        l2     = last2_q[idx];
        cnt    = cnt_q[idx];
        xe     = {{2{x_q[DW-1]}}, x_q};
        l1e    = {{2{l1[DW-1]}}, l1};
        l2e    = {{2{l2[DW-1]}}, l2};
        full   = ord_q ? (xe - (l1e <<< 1) + l2e) : (xe - l1e);
        primed = ord_q ? (cnt >= 2'd2) : (cnt >= 2'd1);
    end

    dif_sat #(
        .DW  (DW),
        .SAT (SAT)
    ) u_sat (
        .full_i (full),
        .data_o (res_data),
        .flag_o (res_flag)
    );

    // Next-state, history and result-register update.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        x_d          = x_q;
        ord_d        = ord_q;
        last1_d      = last1_q;
        last2_d      = last2_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_primed_d = out_primed_q;
        out_sat_d    = out_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    for (int i = 0; i < CH; i++) begin
                        last1_d[i] = '0;
                        last2_d[i] = '0;
                        cnt_d[i]   = '0;
                    end
                end else if (in_valid) begin
                    ch_d    = in_ch;
                    x_d     = in_data;
                    ord_d   = order;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (ch_ok) begin
                    out_data_d   = res_data;
                    out_sat_d    = res_flag;
                    out_primed_d = primed;
                    out_ch_d     = ch_q;
                    last2_d[idx] = l1;
                    last1_d[idx] = x_q;
                    cnt_d[idx]   = (cnt == 2'd2) ? 2'd2 : cnt + 2'd1;
                    state_d      = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Single register bank; reset drops any in-flight sample and history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            x_q          <= '0;
            ord_q        <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_primed_q <= 1'b0;
            out_sat_q    <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                last1_q[i] <= '0;
                last2_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            x_q          <= x_d;
            ord_q        <= ord_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_primed_q <= out_primed_d;
            out_sat_q    <= out_sat_d;
            last1_q      <= last1_d;
            last2_q      <= last2_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE) && !clr;
    assign out_valid  = (state_q == ST_HOLD);
    assign out_ch     = out_ch_q;
    assign out_data   = out_data_q;
    assign out_primed = out_primed_q;
    assign out_sat    = out_sat_q;

endmodule
